// File: rtl/async_fifo_1clk_pkg.sv
// Shared defaults and Gray-code helper for the single-clock async-style FIFO.
// No logic of its own; latency and backpressure are defined by the users of it.
package async_fifo_1clk_pkg;

  localparam int FIFO_DSIZE = 8;
  localparam int FIFO_ASIZE = 4;

  // Zero-extended input keeps the top Gray bit equal to the top binary bit.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/async_fifo_1clk_sync_2ff.sv
// Two-flop pointer synchronizer, parameterized width.
// Latency 2 cycles; no backpressure, samples every edge.
module async_fifo_1clk_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q;

endmodule

// File: rtl/async_fifo_1clk.sv
// 16-deep FIFO with Gray pointers crossed through 2-flop synchronizers on one clock.
// Show-ahead read; empty clears 3 edges after a write, full clears 3 edges after a read.
module async_fifo_1clk
  import async_fifo_1clk_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE,
  parameter int ASIZE = FIFO_ASIZE
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty
);

  localparam int PW    = ASIZE + 1;
  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [DSIZE-1:0] mem_d [DEPTH];

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic          wfull_q, wfull_d;
  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          rempty_q, rempty_d;

  logic [PW-1:0] wq2_rptr;
  logic [PW-1:0] rq2_wptr;
  logic          wr_en;
  logic          rd_en;

  async_fifo_1clk_sync_2ff #(.WIDTH(PW)) u_sync_r2w (
    .clk   (wclk),
    .rst_n (wrst_n),
    .din   (rptr_q),
    .dout  (wq2_rptr)
  );

  async_fifo_1clk_sync_2ff #(.WIDTH(PW)) u_sync_w2r (
    .clk   (wclk),
    .rst_n (wrst_n),
    .din   (wptr_q),
    .dout  (rq2_wptr)
  );

  // Write side: full when the next write pointer laps the synchronized read pointer.
  always_comb begin
    wr_en   = winc & ~wfull_q;
    wbin_d  = wbin_q + {{ASIZE{1'b0}}, wr_en};
    wptr_d  = PW'(bin2gray(32'(wbin_d)));
    wfull_d = (wptr_d == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});
    mem_d   = mem_q;
    if (wr_en) begin
      mem_d[wbin_q[ASIZE-1:0]] = wdata;
    end
  end

  // Read side: empty when the next read pointer catches the synchronized write pointer.
  always_comb begin
    rd_en    = rinc & ~rempty_q;
    rbin_d   = rbin_q + {{ASIZE{1'b0}}, rd_en};
    rptr_d   = PW'(bin2gray(32'(rbin_d)));
    rempty_d = (rptr_d == rq2_wptr);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wbin_q   <= '0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wfull_q  <= wfull_d;
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
    end
  end

  assign rdata  = mem_q[rbin_q[ASIZE-1:0]];
  assign wfull  = wfull_q;
  assign rempty = rempty_q;

endmodule

// File: tb/tb_async_fifo_1clk.sv
// Scoreboard bench: flags predicted from accepted-operation counts and a data queue.
module tb_async_fifo_1clk;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic [7:0] wdata;
  logic       winc;
  logic       wfull;
  logic       rinc;
  logic [7:0] rdata;
  logic       rempty;

  int checks = 0;
  int errors = 0;

  // Reference state: queue of stored words plus the last 4 cumulative
  // accepted-write / accepted-read counts (index 0 = after the latest edge).
  logic [7:0] exp_q[$];
  int         wc_h[$];
  int         rc_h[$];

  always #5 wclk = ~wclk;

  async_fifo_1clk dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .wdata  (wdata),
    .winc   (winc),
    .wfull  (wfull),
    .rinc   (rinc),
    .rdata  (rdata),
    .rempty (rempty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, compares against the model, then advances the
  // model by what will be accepted on the coming rising edge.
  always @(negedge wclk) begin
    bit m_empty, m_full, w_acc, r_acc;
    int wc_new, rc_new;
    if (!wrst_n) begin
      check("rst_rempty", {31'b0, rempty}, 32'd1);
      check("rst_wfull",  {31'b0, wfull},  32'd0);
      check("rst_rdata",  {24'b0, rdata},  32'd0);
      exp_q.delete();
      wc_h = '{0, 0, 0, 0};
      rc_h = '{0, 0, 0, 0};
    end else begin
      // Empty sees writes 3 edges late; full sees reads 3 edges late.
      m_empty = (rc_h[0] == wc_h[3]);
      m_full  = ((wc_h[0] - rc_h[3]) == 16);
      check("rempty", {31'b0, rempty}, {31'b0, m_empty});
      check("wfull",  {31'b0, wfull},  {31'b0, m_full});
      if (!m_empty) begin
        check("rdata", {24'b0, rdata}, {24'b0, exp_q[0]});
      end
      w_acc  = winc && !m_full;
      r_acc  = rinc && !m_empty;
      if (r_acc) void'(exp_q.pop_front());
      if (w_acc) exp_q.push_back(wdata);
      wc_new = wc_h[0] + int'(w_acc);
      rc_new = rc_h[0] + int'(r_acc);
      wc_h.push_front(wc_new);
      rc_h.push_front(rc_new);
      void'(wc_h.pop_back());
      void'(rc_h.pop_back());
    end
  end

  task automatic drive(input bit w, input bit r, input logic [7:0] d);
    winc  = w;
    rinc  = r;
    wdata = d;
    @(posedge wclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic rand_phase(input int n, input int pw, input int pr);
    repeat (n) drive($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom));
  endtask

  initial begin
    logic [7:0] d;
    wrst_n = 1'b0;
    winc   = 1'b0;
    rinc   = 1'b0;
    wdata  = 8'h00;
    wc_h   = '{0, 0, 0, 0};
    rc_h   = '{0, 0, 0, 0};
    #1;

    // Reset with random request pulses that must be ignored.
    repeat (5) drive(1'($urandom), 1'($urandom), 8'($urandom));
    wrst_n = 1'b1;
    idle(2);

    // Three writes, wait for empty to clear, then two pops.
    drive(1'b1, 1'b0, 8'd1);
    drive(1'b1, 1'b0, 8'd2);
    drive(1'b1, 1'b0, 8'd3);
    idle(4);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    idle(3);
    repeat (3) drive(1'b0, 1'b1, 8'h00);
    idle(4);

    // Fill to full, try an extra write, release by one read, refill, drain.
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'(8'h10 + i));
    drive(1'b1, 1'b0, 8'hAA);
    idle(4);
    drive(1'b0, 1'b1, 8'h00);
    idle(4);
    drive(1'b1, 1'b0, 8'h55);
    idle(4);
    repeat (22) drive(1'b0, 1'b1, 8'h00);
    idle(3);

    // Underflow attempts, then a write/read pair.
    repeat (4) drive(1'b0, 1'b1, 8'h00);
    drive(1'b1, 1'b0, 8'h3C);
    idle(3);
    drive(1'b0, 1'b1, 8'h00);
    idle(4);

    // Eight stored words, then 40 cycles of simultaneous read and write across the wrap.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'(8'h80 + i));
    idle(4);
    d = 8'hC0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b1, d);
      d = d + 8'd1;
    end
    idle(4);

    // Randomized traffic biased toward full, toward empty, and balanced.
    rand_phase(150, 80, 30);
    rand_phase(150, 30, 80);
    rand_phase(200, 50, 50);

    // Reset in the middle of traffic, then continue.
    rand_phase(30, 90, 20);
    wrst_n = 1'b0;
    idle(2);
    wrst_n = 1'b1;
    idle(1);
    rand_phase(150, 60, 55);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
